// File: rtl/zap_fetch_pkg.sv
// -----------------------------------------------------------------------------
// zap_fetch_pkg
// Shared types and constants for the fetch buffer and its word FIFO.
//   fetch_entry_t : one fetched word together with its instruction-abort flag.
//   THUMB_PC_INC  : PC step per Thumb instruction (halfword).
//   ARM_PC_INC    : PC step per ARM instruction (word).
// -----------------------------------------------------------------------------
package zap_fetch_pkg;

  typedef struct packed {
    logic        abort;
    logic [31:0] data;
  } fetch_entry_t;

  localparam logic [31:0] THUMB_PC_INC = 32'd2;
  localparam logic [31:0] ARM_PC_INC   = 32'd4;

endpackage

// File: rtl/zap_fetch_buf_fifo.sv
// -----------------------------------------------------------------------------
// zap_fetch_buf_fifo
// Synchronous FIFO of fetch_entry_t words with a flush that empties it.
// Ports:
//   i_clk, i_reset  : clock, synchronous active-high reset
//   flush           : drop all stored words (pointers and count to zero)
//   push, wdata     : write wdata at the tail (caller guarantees not full)
//   pop             : discard the head (caller guarantees not empty)
//   head            : current head entry
//   count           : number of stored entries, 0..DEPTH
//   full, empty     : count==DEPTH / count==0
// Parameter DEPTH must be a power of two, >= 2; pointers wrap naturally.
// -----------------------------------------------------------------------------
module zap_fetch_buf_fifo
  import zap_fetch_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t wdata,
  input  logic         pop,
  output fetch_entry_t head,
  output logic [AW:0]  count,
  output logic         full,
  output logic         empty
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  always_ff @(posedge i_clk) begin
    if (i_reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  // Storage carries no reset; only the pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= wdata;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/zap_thumb_fetch_buffer.sv
// -----------------------------------------------------------------------------
// zap_thumb_fetch_buffer
// Producer end of the fetch -> Thumb-decode interface. Buffers I-cache words
// in a small FIFO and presents one instruction per advance: the full word in
// ARM state, one halfword (low first) in Thumb state. Tracks the fetch PC.
// Ports:
//   i_clk, i_reset              : clock, synchronous active-high reset
//   i_clear_from_writeback      : flush (highest priority)
//   i_data_stall                : hold
//   i_clear_from_alu            : flush
//   i_stall_from_shifter/issue/decode : hold
//   i_clear_from_decode         : flush (lowest priority)
//   i_clear_pc                  : restart PC, taken on any winning flush
//   i_cpsr_ff_t                 : 1 = Thumb state
//   i_mem_data/valid/abort      : word from the I-cache
//   o_mem_ready                 : FIFO can take a word this cycle
//   o_instruction(_valid)       : presented instruction and qualifier
//   o_iabort                    : abort attached to o_instruction
//   o_pc_ff, o_pc_plus_8_ff     : address of o_instruction, and +4(T)/+8(ARM)
// Build option: ZAP_FETCH_BUF_BYPASS_EN loads an arriving word straight into
// the output register when the FIFO is empty and the stage advances.
// -----------------------------------------------------------------------------
module zap_thumb_fetch_buffer
  import zap_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clear_from_writeback,
  input  logic        i_data_stall,
  input  logic        i_clear_from_alu,
  input  logic        i_stall_from_shifter,
  input  logic        i_stall_from_issue,
  input  logic        i_stall_from_decode,
  input  logic        i_clear_from_decode,
  input  logic [31:0] i_clear_pc,
  input  logic        i_cpsr_ff_t,
  input  logic [31:0] i_mem_data,
  input  logic        i_mem_valid,
  input  logic        i_mem_abort,
  output logic        o_mem_ready,
  output logic [31:0] o_instruction,
  output logic        o_instruction_valid,
  output logic        o_iabort,
  output logic [31:0] o_pc_ff,
  output logic [31:0] o_pc_plus_8_ff
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]  pc_ff;      // address of the next instruction to present
  logic         half_ff;    // Thumb: 1 = next output is the high half
  logic         stall_any;
  logic         flush;
  logic         hold;
  logic         advance;

  fetch_entry_t fifo_head;
  logic [AW:0]  fifo_count;
  logic         fifo_full;
  logic         fifo_empty;

  fetch_entry_t src;
  logic         src_vld;
  logic         bypass_take;
  logic         last_half;
  logic         pop;
  logic         push;
  logic [31:0]  instr_sel;
  logic [31:0]  pc_inc;

  // Clear/stall hierarchy: wb clear > data stall > alu clear > other stalls
  // > decode clear; anything left over advances the stage.
  assign stall_any = i_stall_from_shifter | i_stall_from_issue | i_stall_from_decode;
  assign flush     = i_clear_from_writeback |
                     (~i_data_stall & (i_clear_from_alu | (~stall_any & i_clear_from_decode)));
  assign hold      = ~i_clear_from_writeback &
                     (i_data_stall | (~i_clear_from_alu & stall_any));
  assign advance   = ~flush & ~hold;

  assign o_mem_ready = (fifo_count < (AW+1)'(DEPTH));

  always_comb begin
    src         = fifo_head;
    src_vld     = ~fifo_empty;
    bypass_take = 1'b0;
`ifdef ZAP_FETCH_BUF_BYPASS_EN
    if (fifo_empty && advance && i_mem_valid) begin
      src         = '{abort: i_mem_abort, data: i_mem_data};
      src_vld     = 1'b1;
      bypass_take = 1'b1;
    end
`endif
    // The word is fully consumed by this output in ARM state or on the
    // high half in Thumb state.
    last_half = ~i_cpsr_ff_t | half_ff;
    pc_inc    = i_cpsr_ff_t ? THUMB_PC_INC : ARM_PC_INC;
    if (!i_cpsr_ff_t)
      instr_sel = src.data;
    else if (half_ff)
      instr_sel = {16'd0, src.data[31:16]};
    else
      instr_sel = {16'd0, src.data[15:0]};
    pop  = advance & ~fifo_empty & last_half;
    // A bypassed Thumb word whose low half was just used still owes its
    // high half, so it is stored; otherwise a bypassed word skips the FIFO.
    push = i_mem_valid & ~fifo_full & ~flush & ~(bypass_take & last_half);
  end

  zap_fetch_buf_fifo #(.DEPTH(DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .flush   (flush),
    .push    (push),
    .wdata   ('{abort: i_mem_abort, data: i_mem_data}),
    .pop     (pop),
    .head    (fifo_head),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Output register stage
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_instruction       <= '0;
      o_instruction_valid <= 1'b0;
      o_iabort            <= 1'b0;
      o_pc_ff             <= '0;
      o_pc_plus_8_ff      <= '0;
      pc_ff               <= '0;
      half_ff             <= 1'b0;
    end else if (flush) begin
      o_instruction_valid <= 1'b0;
      o_iabort            <= 1'b0;
      o_pc_ff             <= i_clear_pc;
      o_pc_plus_8_ff      <= i_clear_pc + (pc_inc << 1);
      pc_ff               <= i_clear_pc;
      half_ff             <= i_clear_pc[1] & i_cpsr_ff_t;
    end else if (advance) begin
      if (src_vld) begin
        o_instruction       <= instr_sel;
        o_instruction_valid <= 1'b1;
        o_iabort            <= src.abort;
        o_pc_ff             <= pc_ff;
        o_pc_plus_8_ff      <= pc_ff + (pc_inc << 1);
        pc_ff               <= pc_ff + pc_inc;
        half_ff             <= i_cpsr_ff_t & ~half_ff;
      end else begin
        o_instruction_valid <= 1'b0;
        o_iabort            <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_zap_thumb_fetch_buffer.sv
module tb_zap_thumb_fetch_buffer;

  logic        clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_clear_from_writeback = 1'b0;
  logic        i_data_stall = 1'b0;
  logic        i_clear_from_alu = 1'b0;
  logic        i_stall_from_shifter = 1'b0;
  logic        i_stall_from_issue = 1'b0;
  logic        i_stall_from_decode = 1'b0;
  logic        i_clear_from_decode = 1'b0;
  logic [31:0] i_clear_pc = '0;
  logic        i_cpsr_ff_t = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic        i_mem_valid = 1'b0;
  logic        i_mem_abort = 1'b0;
  logic        o_mem_ready;
  logic [31:0] o_instruction;
  logic        o_instruction_valid;
  logic        o_iabort;
  logic [31:0] o_pc_ff;
  logic [31:0] o_pc_plus_8_ff;

  always #5 clk = ~clk;

  zap_thumb_fetch_buffer #(.DEPTH(4)) dut (
    .i_clk                  (clk),
    .i_reset                (i_reset),
    .i_clear_from_writeback (i_clear_from_writeback),
    .i_data_stall           (i_data_stall),
    .i_clear_from_alu       (i_clear_from_alu),
    .i_stall_from_shifter   (i_stall_from_shifter),
    .i_stall_from_issue     (i_stall_from_issue),
    .i_stall_from_decode    (i_stall_from_decode),
    .i_clear_from_decode    (i_clear_from_decode),
    .i_clear_pc             (i_clear_pc),
    .i_cpsr_ff_t            (i_cpsr_ff_t),
    .i_mem_data             (i_mem_data),
    .i_mem_valid            (i_mem_valid),
    .i_mem_abort            (i_mem_abort),
    .o_mem_ready            (o_mem_ready),
    .o_instruction          (o_instruction),
    .o_instruction_valid    (o_instruction_valid),
    .o_iabort               (o_iabort),
    .o_pc_ff                (o_pc_ff),
    .o_pc_plus_8_ff         (o_pc_plus_8_ff)
  );

  typedef struct {
    logic        in_vld;
    logic [31:0] word;
    logic        in_abort;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_pc8;
    logic        exp_abort;
  } vec_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc8;
    logic        abort;
  } out_t;

  vec_t vecs [9];
  out_t got_q [$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Records every instruction newly presented on an advancing edge.
  logic mon_adv;
  always @(posedge clk) begin
    mon_adv = !i_reset && !i_clear_from_writeback && !i_data_stall && !i_clear_from_alu &&
              !(i_stall_from_shifter || i_stall_from_issue || i_stall_from_decode) &&
              !i_clear_from_decode;
    #1;
    if (mon_adv && o_instruction_valid)
      got_q.push_back('{instr: o_instruction, pc: o_pc_ff, pc8: o_pc_plus_8_ff, abort: o_iabort});
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_flush(input int kind, input logic [31:0] pc, input logic t);
    i_clear_pc  = pc;
    i_cpsr_ff_t = t;
    case (kind)
      0:       i_clear_from_writeback = 1'b1;
      1:       i_clear_from_alu = 1'b1;
      default: i_clear_from_decode = 1'b1;
    endcase
    step();
    i_clear_from_writeback = 1'b0;
    i_clear_from_alu = 1'b0;
    i_clear_from_decode = 1'b0;
    got_q.delete();
    check("flush_valid", o_instruction_valid, 1'b0);
    check("flush_pc", o_pc_ff, pc);
    check("flush_pc8", o_pc_plus_8_ff, pc + (t ? 32'd4 : 32'd8));
  endtask

  task automatic wait_outputs(input string name, input int n, input int budget);
    int c = 0;
    while (got_q.size() < n && c < budget) begin
      step();
      c++;
    end
    repeat (3) step();
    check({name, "_count"}, got_q.size(), n);
  endtask

  task automatic run_stream(input string name, input int first, input int last);
    int n = last - first + 1;
    for (int i = first; i <= last; i++) begin
      if (vecs[i].in_vld) begin
        i_mem_valid = 1'b1;
        i_mem_data  = vecs[i].word;
        i_mem_abort = vecs[i].in_abort;
        step();
      end
    end
    i_mem_valid = 1'b0;
    i_mem_abort = 1'b0;
    wait_outputs(name, n, 30);
    for (int i = 0; i < n; i++) begin
      if (i < got_q.size())
        check($sformatf("%s_out%0d", name, i), got_q[i],
              {vecs[first+i].exp_instr, vecs[first+i].exp_pc,
               vecs[first+i].exp_pc8, vecs[first+i].exp_abort});
    end
  endtask

  initial begin
    int acc;
    int c;
    logic will_acc;

    // ARM stream after a writeback clear to 0x100
    vecs[0] = '{1'b1, 32'hE3A00001, 1'b0, 32'hE3A00001, 32'h100, 32'h108, 1'b0};
    vecs[1] = '{1'b1, 32'hE3A01002, 1'b0, 32'hE3A01002, 32'h104, 32'h10C, 1'b0};
    // Thumb stream after an ALU clear to 0x202 (starts on the high half)
    vecs[2] = '{1'b1, 32'h11112222, 1'b0, 32'h00001111, 32'h202, 32'h206, 1'b0};
    vecs[3] = '{1'b1, 32'h33334444, 1'b0, 32'h00004444, 32'h204, 32'h208, 1'b0};
    vecs[4] = '{1'b0, 32'h0,        1'b0, 32'h00003333, 32'h206, 32'h20A, 1'b0};
    // Thumb abort stream after a decode clear to 0x300
    vecs[5] = '{1'b1, 32'hAAAA5555, 1'b1, 32'h00005555, 32'h300, 32'h304, 1'b1};
    vecs[6] = '{1'b0, 32'h0,        1'b0, 32'h0000AAAA, 32'h302, 32'h306, 1'b1};
    vecs[7] = '{1'b1, 32'h0000BEEF, 1'b0, 32'h0000BEEF, 32'h304, 32'h308, 1'b0};
    vecs[8] = '{1'b0, 32'h0,        1'b0, 32'h00000000, 32'h306, 32'h30A, 1'b0};

    // Reset
    i_reset = 1'b1;
    step();
    step();
    check("rst_valid", o_instruction_valid, 1'b0);
    check("rst_pc", o_pc_ff, 32'h0);
    check("rst_pc8", o_pc_plus_8_ff, 32'h0);
    check("rst_ready", o_mem_ready, 1'b1);
    check("rst_instr", o_instruction, 32'h0);
    check("rst_iabort", o_iabort, 1'b0);
    i_reset = 1'b0;
    step();

    do_flush(0, 32'h100, 1'b0);
    run_stream("arm", 0, 1);
    do_flush(1, 32'h202, 1'b1);
    run_stream("thumb", 2, 4);
    do_flush(2, 32'h300, 1'b1);
    run_stream("abort", 5, 8);

    // FIFO fill under an issue stall, then drain
    do_flush(0, 32'h400, 1'b0);
    i_stall_from_issue = 1'b1;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      i_mem_valid = (acc < 6);
      i_mem_data  = 32'hA000_0000 + 32'(acc);
      will_acc    = i_mem_valid && o_mem_ready;
      step();
      if (will_acc) acc++;
    end
    check("full_stored", acc, 4);
    check("full_ready", o_mem_ready, 1'b0);
    check("full_valid_held", o_instruction_valid, 1'b0);
    i_stall_from_issue = 1'b0;
    c = 0;
    while (acc < 6 && c < 20) begin
      i_mem_valid = 1'b1;
      i_mem_data  = 32'hA000_0000 + 32'(acc);
      will_acc    = o_mem_ready;
      step();
      if (will_acc) acc++;
      c++;
    end
    i_mem_valid = 1'b0;
    check("full_all_accepted", acc, 6);
    wait_outputs("full", 6, 40);
    for (int k = 0; k < 6; k++) begin
      if (k < got_q.size())
        check($sformatf("full_out%0d", k), got_q[k],
              {32'hA000_0000 + 32'(k), 32'h400 + 32'(4*k), 32'h408 + 32'(4*k), 1'b0});
    end

    // Data stall beats an ALU clear; the clear lands once the stall drops
    do_flush(0, 32'h500, 1'b0);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h12345678;
    step();
    i_mem_valid = 1'b0;
    c = 0;
    while (!o_instruction_valid && c < 10) begin
      step();
      c++;
    end
    check("prio_first_valid", o_instruction_valid, 1'b1);
    i_data_stall     = 1'b1;
    i_clear_from_alu = 1'b1;
    i_clear_pc       = 32'h600;
    i_mem_valid      = 1'b1;
    i_mem_data       = 32'h9ABCDEF0;
    step();
    i_mem_valid = 1'b0;
    check("prio_hold_valid", o_instruction_valid, 1'b1);
    check("prio_hold_instr", o_instruction, 32'h12345678);
    check("prio_hold_pc", o_pc_ff, 32'h500);
    step();
    check("prio_hold2_instr", o_instruction, 32'h12345678);
    i_data_stall = 1'b0;
    step();
    check("prio_clr_valid", o_instruction_valid, 1'b0);
    check("prio_clr_pc", o_pc_ff, 32'h600);
    check("prio_clr_pc8", o_pc_plus_8_ff, 32'h608);
    check("prio_clr_iabort", o_iabort, 1'b0);
    i_clear_from_alu = 1'b0;
    got_q.delete();
    repeat (6) step();
    check("prio_fifo_empty", got_q.size(), 0);
    check("prio_idle_valid", o_instruction_valid, 1'b0);

    // Reset in the middle of a Thumb stream
    do_flush(1, 32'h800, 1'b1);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'h55556666;
    step();
    i_mem_data  = 32'h77778888;
    step();
    i_reset     = 1'b1;
    i_cpsr_ff_t = 1'b0;
    i_mem_data  = 32'h9999AAAA;
    step();
    i_mem_valid = 1'b0;
    check("mrst_valid", o_instruction_valid, 1'b0);
    check("mrst_pc", o_pc_ff, 32'h0);
    check("mrst_instr", o_instruction, 32'h0);
    check("mrst_ready", o_mem_ready, 1'b1);
    i_reset = 1'b0;
    got_q.delete();
    repeat (5) step();
    check("mrst_no_leftover", got_q.size(), 0);
    i_mem_valid = 1'b1;
    i_mem_data  = 32'hCAFEF00D;
    step();
    i_mem_valid = 1'b0;
    wait_outputs("mrst_after", 1, 10);
    if (got_q.size() > 0)
      check("mrst_after_out", got_q[0], {32'hCAFEF00D, 32'h0, 32'h8, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
